// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Programming-side driver for the fabric configuration chain. Bitstream
//   words arrive over a valid/ready stream and are shifted LSB-first into
//   ccff_head. The bits leaving ccff_tail are packed back into readback words
//   so the previous chain contents can be checked.
//
// Parameters
//   WORD_W     width of bitstream and readback words
//   CHAIN_LEN  total configuration bits in the chain (any value >= 1)
//
// Ports
//   clk            clock shared with the fabric chain DFFs
//   reset          synchronous active-high reset
//   start          one-cycle pulse, starts a pass (honoured only when idle)
//   in_data        bitstream word, bit 0 shifted first
//   in_valid       in_data valid
//   in_ready       word accepted this cycle (decoded from state only)
//   ccff_head      serial data into the chain
//   ccff_shift_en  chain shifts on every clk edge where this is high
//   ccff_tail      serial data out of the chain
//   rb_data        readback word, bit 0 = first tail bit of the word
//   rb_valid       one-cycle pulse qualifying rb_data (no backpressure)
//   busy           pass in progress
//   done           one-cycle pulse when the pass completes
//   crc            CRC-16-CCITT over the tail bits when CCFF_TAIL_CRC_EN
//                  is defined; tied to 0 otherwise
//
// Build option
//   CCFF_TAIL_CRC_EN  builds the tail CRC (poly 0x1021, init 0xFFFF).
module ccff_chain_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [IDX_W-1:0]  r_widx;
  logic [WORD_W-1:0] r_rb_sreg;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;

  logic              w_start;
  logic              w_accept;
  logic              w_shift;
  logic              w_last_bit;
  logic              w_word_end;
  logic [WORD_W-1:0] w_rb_next;

  assign w_start    = start && (r_state == S_IDLE);
  assign w_accept   = in_valid && (r_state == S_LOAD);
  assign w_shift    = (r_state == S_SHIFT);
  assign w_last_bit = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end = (r_widx == IDX_W'(WORD_W - 1));

  // Readback word with the bit leaving the chain at this edge merged in.
  always_comb begin
    w_rb_next         = r_rb_sreg;
    w_rb_next[r_widx] = ccff_tail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)    w_state_nxt = S_LOAD;
      S_LOAD:  if (in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        // The chain end takes priority over the word boundary, which is how
        // the tail of a partial last word gets dropped.
        if (w_last_bit)      w_state_nxt = S_DONE;
        else if (w_word_end) w_state_nxt = S_LOAD;
      end
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_SHIFT: begin
        ccff_shift_en = 1'b1;
        ccff_head     = r_sreg[0];
        busy          = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_widx     <= '0;
      r_rb_sreg  <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_widx    <= '0;
        r_rb_sreg <= '0;
      end
      if (w_accept) begin
        r_sreg <= in_data;
      end
      if (w_shift) begin
        r_sreg    <= r_sreg >> 1;
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_widx    <= w_word_end ? '0 : r_widx + 1'b1;
        if (w_word_end || w_last_bit) begin
          // Clearing the collector makes uncollected bits of a partial
          // final word read as 0.
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_sreg  <= '0;
        end else begin
          r_rb_sreg <= w_rb_next;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;

`ifdef CCFF_TAIL_CRC_EN
  logic [15:0] r_crc;
  logic        w_crc_fb;

  assign w_crc_fb = r_crc[15] ^ ccff_tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= '0;
    end else if (w_start) begin
      r_crc <= 16'hFFFF;
    end else if (w_shift) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign crc = r_crc;
`else
  assign crc = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: CHAIN_LEN=8, WORD_W=4
  logic        st8, vd8, rdy8, hd8, se8, tl8, rbv8, bsy8, dn8;
  logic [3:0]  dt8, rbd8;
  logic [15:0] crc8;
  // DUT B: CHAIN_LEN=6, WORD_W=4
  logic        st6, vd6, rdy6, hd6, se6, tl6, rbv6, bsy6, dn6;
  logic [3:0]  dt6, rbd6;
  logic [15:0] crc6;

  ccff_chain_loader #(.WORD_W(4), .CHAIN_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .in_data(dt8), .in_valid(vd8),
    .in_ready(rdy8), .ccff_head(hd8), .ccff_shift_en(se8), .ccff_tail(tl8),
    .rb_data(rbd8), .rb_valid(rbv8), .busy(bsy8), .done(dn8), .crc(crc8)
  );

  ccff_chain_loader #(.WORD_W(4), .CHAIN_LEN(6)) dut6 (
    .clk(clk), .reset(reset), .start(st6), .in_data(dt6), .in_valid(vd6),
    .in_ready(rdy6), .ccff_head(hd6), .ccff_shift_en(se6), .ccff_tail(tl6),
    .rb_data(rbd6), .rb_valid(rbv6), .busy(bsy6), .done(dn6), .crc(crc6)
  );

`ifdef CCFF_TAIL_CRC_EN
  localparam logic [15:0] CRC_ZERO8 = 16'hE1F0;  // eight 0 bits from 0xFFFF
`else
  localparam logic [15:0] CRC_ZERO8 = 16'h0000;
`endif

  // Fabric chain models: head enters at bit 0, tail is the top bit.
  logic [7:0] chain8 = '0;
  logic [5:0] chain6 = '0;
  assign tl8 = chain8[7];
  assign tl6 = chain6[5];

  logic       s8 = 1'b0, h8 = 1'b0, s6 = 1'b0, h6 = 1'b0;
  logic [7:0] hlog8;
  logic [5:0] hlog6;
  int         nsh8, nsh6;
  logic [3:0] rbq8[$];
  logic [3:0] rbq6[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         sc, dc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    s8 = se8; h8 = hd8; s6 = se6; h6 = hd6;
    if (se8) begin hlog8 = {hlog8[6:0], hd8}; nsh8++; end
    if (se6) begin hlog6 = {hlog6[4:0], hd6}; nsh6++; end
    if (rbv8) rbq8.push_back(rbd8);
    if (rbv6) rbq6.push_back(rbd6);
  end

  always @(posedge clk) begin
    if (s8) chain8 <= {chain8[6:0], h8};
    if (s6) chain6 <= {chain6[4:0], h6};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_rdy(input int d);
    return (d == 0) ? rdy8 : rdy6;
  endfunction

  function automatic logic f_done(input int d);
    return (d == 0) ? dn8 : dn6;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic do_start(input int d);
    if (d == 0) begin st8 = 1'b1; nsh8 = 0; hlog8 = '0; rbq8.delete(); end
    else        begin st6 = 1'b1; nsh6 = 0; hlog6 = '0; rbq6.delete(); end
    sc = cyc;
    @(negedge clk);
    st8 = 1'b0;
    st6 = 1'b0;
  endtask

  task automatic feed(input int d, input logic [3:0] w);
    logic ok = 1'b0;
    int   n  = 0;
    if (d == 0) begin vd8 = 1'b1; dt8 = w; end
    else        begin vd6 = 1'b1; dt6 = w; end
    while (!ok && n < 50) begin
      ok = f_rdy(d);
      @(negedge clk);
      n++;
    end
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int d, output int dcyc);
    int n = 0;
    vd8 = 1'b0;
    vd6 = 1'b0;
    while (!f_done(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    dcyc = cyc;
    check("done_seen", 32'(f_done(d)), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    st8 = 1'b0; vd8 = 1'b0; dt8 = '0;
    st6 = 1'b0; vd6 = 1'b0; dt6 = '0;
    repeat (3) @(negedge clk);
    check("rst_out8", 32'({bsy8, rdy8, se8, hd8, rbv8, dn8, rbd8}), 32'd0);
    check("rst_out6", 32'({bsy6, rdy6, se6, hd6, rbv6, dn6, rbd6}), 32'd0);
    check("rst_crc8", 32'(crc8), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy8", 32'(bsy8), 32'd0);

    // Pass 1 on 8-bit chain (preloaded 0x00), valid held high
    do_start(0);
    check("load_state8", 32'({bsy8, rdy8, se8}), 32'b110);
    feed(0, 4'h5);
    feed(0, 4'hA);
    wait_done(0, dc);
    check("p1_done_cycle", 32'(dc - sc + 1), 32'd12);  // 8 + 2 + 2
    check("p1_crc", 32'(crc8), 32'(CRC_ZERO8));
    @(negedge clk);
    check("p1_done_1cyc", 32'({dn8, bsy8}), 32'd0);
    check("p1_head_seq", 32'(hlog8), 32'hA5);
    check("p1_shifts", 32'(nsh8), 32'd8);
    check("p1_chain", 32'(chain8), 32'hA5);
    check("p1_rb_cnt", 32'(rbq8.size()), 32'd2);
    check("p1_rb0", 32'((rbq8.size() > 0) ? rbq8[0] : 4'hx), 32'h0);
    check("p1_rb1", 32'((rbq8.size() > 1) ? rbq8[1] : 4'hx), 32'h0);

    // Pass 2: stalled second word, stray start mid-pass
    do_start(0);
    feed(0, 4'h3);
    st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    vd8 = 1'b0;
    for (int n = 0; n < 20 && !rdy8; n++) @(negedge clk);
    check("stall_begin", 32'({rdy8, se8}), 32'b10);
    repeat (5) @(negedge clk);
    check("stall_end", 32'({rdy8, se8, bsy8}), 32'b101);
    feed(0, 4'hC);
    wait_done(0, dc);
    @(negedge clk);
    check("p2_shifts", 32'(nsh8), 32'd8);
    check("p2_chain", 32'(chain8), 32'hC3);
    check("p2_rb_cnt", 32'(rbq8.size()), 32'd2);
    check("p2_rb0", 32'((rbq8.size() > 0) ? rbq8[0] : 4'hx), 32'h5);
    check("p2_rb1", 32'((rbq8.size() > 1) ? rbq8[1] : 4'hx), 32'hA);

    // 6-bit chain: partial last word
    do_start(1);
    feed(1, 4'hF);
    feed(1, 4'hF);
    wait_done(1, dc);
    check("c6_done_cycle", 32'(dc - sc + 1), 32'd10);  // 6 + 2 + 2
    @(negedge clk);
    check("c6_shifts", 32'(nsh6), 32'd6);
    check("c6_chain", 32'(chain6), 32'h3F);
    check("c6_rb_cnt", 32'(rbq6.size()), 32'd2);
    check("c6_rb0", 32'((rbq6.size() > 0) ? rbq6[0] : 4'hx), 32'h0);
    check("c6_rb1", 32'((rbq6.size() > 1) ? rbq6[1] : 4'hx), 32'h0);

    do_start(1);
    feed(1, 4'hF);
    feed(1, 4'hF);
    wait_done(1, dc);
    @(negedge clk);
    check("c6b_shifts", 32'(nsh6), 32'd6);
    check("c6b_rb0", 32'((rbq6.size() > 0) ? rbq6[0] : 4'hx), 32'hF);
    check("c6b_rb1", 32'((rbq6.size() > 1) ? rbq6[1] : 4'hx), 32'h3);

    // Reset during SHIFT bit 3, with start coincident
    do_start(0);
    feed(0, 4'h6);
    begin
      int k = 0;
      int n = 0;
      while (!(se8 && k == 3) && n < 20) begin
        if (se8) k++;
        @(negedge clk);
        n++;
      end
      check("rst_bit3_seen", 32'(k), 32'd3);
    end
    reset = 1'b1;
    st8 = 1'b1;
    vd8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    st8 = 1'b0;
    vd8 = 1'b0;
    check("rst_mid", 32'({bsy8, se8, rdy8, dn8, rbv8}), 32'd0);
    @(negedge clk);
    check("rst_start_lost", 32'(bsy8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
